// File: rtl/mem_resp_ctrl.sv
// -----------------------------------------------------------------------------
// mem_resp_ctrl -- data-memory responder for the memory-stage request interface.
//
// Serves one request at a time from an internal word-addressed RAM. Requests
// come from the MEM-stage data port (read/write with byte lanes) and from the
// instruction-fetch port (read only). Each accepted access completes LATENCY
// cycles after the cycle it was seen in IDLE.
//
// Optional feature macro: MEM_RR_ARB_EN
//   defined   -> round-robin arbitration between the two ports
//   undefined -> fixed priority, data port over inst port
//
// Parameters:
//   DEPTH    RAM size in 32-bit words (power of two)
//   LATENCY  cycles from accept to done pulse (1..15)
//
// Ports:
//   clk       system clock
//   rst       asynchronous active-low reset
//   d_re      data-port read request (level)
//   d_we      data-port write request (level, wins over d_re)
//   d_sel     byte-lane enables, bit i covers d_wdata[8i+7:8i]
//   d_addr    data-port byte address
//   d_wdata   data-port write data
//   i_re      inst-port read request (level)
//   i_addr    inst-port byte address
//   rdata_o   read data, valid in the done cycle, held until the next read
//   busy_o    {inst, data} busy, combinational
//   done_o    {inst, data} one-cycle completion pulse, registered
//
// Handshake: a requester raises its request level and holds it (with stable
// address/data) until it sees its done_o bit; the access is taken when the
// responder is IDLE, and busy_o[k] stays high until the done cycle. Dropping a
// request after acceptance does not cancel the access.
// -----------------------------------------------------------------------------
module mem_resp_ctrl #(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        d_re,
    input  logic        d_we,
    input  logic [3:0]  d_sel,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic        i_re,
    input  logic [31:0] i_addr,
    output logic [31:0] rdata_o,
    output logic [1:0]  busy_o,
    output logic [1:0]  done_o
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic {IDLE, ACCESS} state_e;

    state_e          state_q, state_d;
    logic            owner_q, owner_d;   // 0 = data port, 1 = inst port
    logic [AW-1:0]   idx_q, idx_d;
    logic [3:0]      sel_q, sel_d;
    logic [31:0]     wdata_q, wdata_d;
    logic            we_q, we_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [1:0]      done_q, done_d;
    logic [31:0]     rdata_q, rdata_d;

    logic            d_req, i_req;
    logic            pick_inst;
    logic            fire;

    logic [31:0]     mem [DEPTH];

    // Address bits outside the word index are ignored (addresses wrap).
    logic            unused_addr_bits;
    assign unused_addr_bits = ^{d_addr[31:AW+2], d_addr[1:0],
                                i_addr[31:AW+2], i_addr[1:0]};

    assign d_req = d_re | d_we;
    assign i_req = i_re;

`ifdef MEM_RR_ARB_EN
    // rr_q names the preferred port when both request; it flips to the other
    // port after every completion.
    logic rr_q, rr_d;
    assign pick_inst = i_req & (~d_req | rr_q);
`else
    assign pick_inst = i_req & ~d_req;
`endif

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        idx_d   = idx_q;
        sel_d   = sel_q;
        wdata_d = wdata_q;
        we_d    = we_q;
        cnt_d   = cnt_q;

        case (state_q)
            IDLE: begin
                if (d_req | i_req) begin
                    state_d = ACCESS;
                    owner_d = pick_inst;
                    idx_d   = pick_inst ? i_addr[AW+1:2] : d_addr[AW+1:2];
                    sel_d   = d_sel;
                    wdata_d = d_wdata;
                    we_d    = ~pick_inst & d_we;
                    cnt_d   = 4'(LATENCY - 1);
                end
            end
            ACCESS: begin
                if (cnt_q == 4'd0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        // The access completes on the edge that enters the counter==0 cycle,
        // so done_o and rdata_o are registered into that cycle. With
        // LATENCY==1 this is the accept edge itself, hence the use of *_d.
        fire = rst && (state_d == ACCESS) && (cnt_d == 4'd0);

        rdata_d = rdata_q;
        if (fire && !we_d) begin
            rdata_d = mem[idx_d];
        end
        done_d = fire ? {owner_d, ~owner_d} : 2'b00;
    end

`ifdef MEM_RR_ARB_EN
    always_comb begin
        rr_d = rr_q;
        if (fire) begin
            rr_d = ~owner_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_q <= 1'b0;
        end else begin
            rr_q <= rr_d;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            idx_q   <= '0;
            sel_q   <= 4'h0;
            wdata_q <= 32'h0;
            we_q    <= 1'b0;
            cnt_q   <= 4'd0;
            done_q  <= 2'b00;
            rdata_q <= 32'h0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            idx_q   <= idx_d;
            sel_q   <= sel_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            rdata_q <= rdata_d;
        end
    end

    // RAM is never cleared; a reset before the completion edge drops the write
    // because fire is gated by rst and the FSM is held in IDLE.
    always_ff @(posedge clk) begin
        if (fire && we_d) begin
            for (int i = 0; i < 4; i++) begin
                if (sel_d[i]) begin
                    mem[idx_d][8*i +: 8] <= wdata_d[8*i +: 8];
                end
            end
        end
    end

    assign rdata_o = rdata_q;
    assign done_o  = done_q;
    assign busy_o  = {i_req, d_req} & ~done_q;

endmodule

// File: tb/tb_mem_resp_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mem_resp_ctrl -- self-checking bench for mem_resp_ctrl.
//
// A transaction-level reference (word-indexed memory plus a "free / busy until
// cycle X" schedule) predicts done_o, busy_o and rdata_o every cycle. Directed
// stimulus also pushes hand-computed read results into exp_q and checks
// hand-computed latencies and busy durations.
// Honours MEM_RR_ARB_EN for the expected arbitration order.
// -----------------------------------------------------------------------------
module tb_mem_resp_ctrl;

    localparam int DEPTH = 1024;
    localparam int LAT   = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        d_re = 1'b0;
    logic        d_we = 1'b0;
    logic [3:0]  d_sel = 4'h0;
    logic [31:0] d_addr = 32'h0;
    logic [31:0] d_wdata = 32'h0;
    logic        i_re = 1'b0;
    logic [31:0] i_addr = 32'h0;
    logic [31:0] rdata_o;
    logic [1:0]  busy_o;
    logic [1:0]  done_o;

    mem_resp_ctrl #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
        .clk     (clk),
        .rst     (rst),
        .d_re    (d_re),
        .d_we    (d_we),
        .d_sel   (d_sel),
        .d_addr  (d_addr),
        .d_wdata (d_wdata),
        .i_re    (i_re),
        .i_addr  (i_addr),
        .rdata_o (rdata_o),
        .busy_o  (busy_o),
        .done_o  (done_o)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] ref_mem [int];
    bit          m_active   = 1'b0;
    bit          m_owner    = 1'b0;
    int          m_idx      = 0;
    logic [3:0]  m_sel      = 4'h0;
    logic [31:0] m_wdata    = 32'h0;
    bit          m_we       = 1'b0;
    int          m_done_cyc = 0;
    logic [31:0] m_rdata    = 32'h0;
    bit          m_rd_known = 1'b1;
    bit          m_rr       = 1'b0;
    int          cyc        = 0;

    always @(negedge clk) begin
        logic [1:0]  e_done;
        logic [1:0]  e_busy;
        logic [31:0] w;
        bit          rd_done;
        bit          dreq;
        bit          ireq;
        bit          own;

        e_done  = 2'b00;
        rd_done = 1'b0;
        dreq    = d_re | d_we;
        ireq    = i_re;

        if (!rst) begin
            m_active   = 1'b0;
            m_rdata    = 32'h0;
            m_rd_known = 1'b1;
            m_rr       = 1'b0;
        end else if (m_active && cyc == m_done_cyc) begin
            e_done = m_owner ? 2'b10 : 2'b01;
            if (m_we) begin
                w = ref_mem.exists(m_idx) ? ref_mem[m_idx] : 32'h0;
                for (int i = 0; i < 4; i++) begin
                    if (m_sel[i]) w[8*i +: 8] = m_wdata[8*i +: 8];
                end
                ref_mem[m_idx] = w;
            end else begin
                rd_done = 1'b1;
                if (ref_mem.exists(m_idx)) begin
                    m_rdata    = ref_mem[m_idx];
                    m_rd_known = 1'b1;
                end else begin
                    m_rd_known = 1'b0;
                end
            end
        end

        e_busy = {ireq, dreq} & ~e_done;
        check("done_o", {30'b0, done_o}, {30'b0, e_done});
        check("busy_o", {30'b0, busy_o}, {30'b0, e_busy});
        if (m_rd_known) check("rdata_o", rdata_o, m_rdata);

        if (rd_done) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rd_literal: read completed with data %h but none expected", rdata_o);
            end else begin
                check("rd_literal", rdata_o, exp_q.pop_front());
            end
        end

        if (rst) begin
            if (m_active && cyc == m_done_cyc) begin
                m_active = 1'b0;
                m_rr     = ~m_owner;
            end else if (!m_active && (dreq || ireq)) begin
`ifdef MEM_RR_ARB_EN
                own = (dreq && ireq) ? m_rr : !dreq;
`else
                own = !dreq;
`endif
                m_active   = 1'b1;
                m_owner    = own;
                m_idx      = int'(((own ? i_addr : d_addr) >> 2) & (DEPTH - 1));
                m_sel      = d_sel;
                m_wdata    = d_wdata;
                m_we       = !own && d_we;
                m_done_cyc = cyc + LAT;
            end
        end
        cyc++;
    end

    // ---------------- driver tasks ----------------
    task automatic data_op(input bit we, input logic [3:0] sel, input logic [31:0] addr,
                           input logic [31:0] wdata, output int lat, output int bcnt);
        @(posedge clk); #1;
        d_re = !we; d_we = we; d_sel = sel; d_addr = addr; d_wdata = wdata;
        lat  = -1;
        bcnt = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done_o[0]) begin
                lat = k;
                break;
            end
            if (busy_o[0]) bcnt++;
        end
        if (lat < 0) begin
            checks++;
            errors++;
            $display("FAIL data_timeout: no done_o[0] within 40 cycles for addr %h", addr);
        end
        @(posedge clk); #1;
        d_re = 1'b0; d_we = 1'b0;
    endtask

    task automatic inst_op(input logic [31:0] addr, output int lat, output int bcnt);
        @(posedge clk); #1;
        i_re = 1'b1; i_addr = addr;
        lat  = -1;
        bcnt = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done_o[1]) begin
                lat = k;
                break;
            end
            if (busy_o[1]) bcnt++;
        end
        if (lat < 0) begin
            checks++;
            errors++;
            $display("FAIL inst_timeout: no done_o[1] within 40 cycles for addr %h", addr);
        end
        @(posedge clk); #1;
        i_re = 1'b0;
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        int lat, bc, lat_d, bc_d, lat_i, bc_i;

        #2 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;

        // Full word write, then read back.
        data_op(1'b1, 4'hF, 32'h10, 32'hDEADBEEF, lat, bc);
        check("wr_latency", 32'(lat), 32'd2);
        check("wr_busy_cycles", 32'(bc), 32'd2);
        exp_q.push_back(32'hDEADBEEF);
        data_op(1'b0, 4'hF, 32'h10, 32'h0, lat, bc);
        check("rd_latency", 32'(lat), 32'd2);

        // Single byte lane write.
        data_op(1'b1, 4'b0100, 32'h10, 32'h00AA0000, lat, bc);
        exp_q.push_back(32'hDEAABEEF);
        data_op(1'b0, 4'h0, 32'h10, 32'h0, lat, bc);

        // sel=0 write is a no-op.
        data_op(1'b1, 4'h0, 32'h10, 32'hFFFFFFFF, lat, bc);
        exp_q.push_back(32'hDEAABEEF);
        data_op(1'b0, 4'hF, 32'h10, 32'h0, lat, bc);

        data_op(1'b1, 4'hF, 32'h20, 32'hCAFEF00D, lat, bc);
        data_op(1'b1, 4'hF, 32'h40, 32'h11223344, lat, bc);

        // Contention: both ports request in the same cycle.
`ifdef MEM_RR_ARB_EN
        exp_q.push_back(32'hCAFEF00D);
        exp_q.push_back(32'hDEAABEEF);
`else
        exp_q.push_back(32'hDEAABEEF);
        exp_q.push_back(32'hCAFEF00D);
`endif
        fork
            data_op(1'b0, 4'hF, 32'h10, 32'h0, lat_d, bc_d);
            inst_op(32'h20, lat_i, bc_i);
        join
`ifdef MEM_RR_ARB_EN
        check("cont_inst_lat", 32'(lat_i), 32'd2);
        check("cont_data_lat", 32'(lat_d), 32'd5);
        check("cont_data_busy", 32'(bc_d), 32'd5);
`else
        check("cont_data_lat", 32'(lat_d), 32'd2);
        check("cont_inst_lat", 32'(lat_i), 32'd5);
        check("cont_inst_busy", 32'(bc_i), 32'd5);
`endif

        // Address wrap: 0x1010 aliases 0x10 with DEPTH=1024.
        exp_q.push_back(32'hDEAABEEF);
        data_op(1'b0, 4'hF, 32'h1010, 32'h0, lat, bc);

        // Reset one cycle after accept aborts the write.
        @(posedge clk); #1;
        d_we = 1'b1; d_sel = 4'hF; d_addr = 32'h40; d_wdata = 32'h12345678;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("abort_done_a", {30'b0, done_o}, 32'd0);
        @(posedge clk); #1;
        d_we = 1'b0;
        @(negedge clk);
        check("abort_done_b", {30'b0, done_o}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        exp_q.push_back(32'h11223344);
        data_op(1'b0, 4'hF, 32'h40, 32'h0, lat, bc);

        // Reset held with d_re asserted, then release.
        @(posedge clk); #1;
        rst = 1'b0; d_re = 1'b1; d_addr = 32'h10; d_sel = 4'hF;
        @(negedge clk);
        check("rst_busy", {30'b0, busy_o}, 32'd1);
        check("rst_done", {30'b0, done_o}, 32'd0);
        check("rst_rdata", rdata_o, 32'h0);
        exp_q.push_back(32'hDEAABEEF);
        @(posedge clk); #1;
        rst = 1'b1;
        lat = -1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done_o[0]) begin
                lat = k;
                break;
            end
        end
        check("rst_release_lat", 32'(lat), 32'd2);
        @(posedge clk); #1;
        d_re = 1'b0;

        repeat (4) @(posedge clk);
        check("exp_q_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_resp_ctrl.md
Name: mem_resp_ctrl

Overview:
- Data-memory responder for the memory-stage request interface.
- Accepts word/byte-lane read and write requests from the MEM stage (data port) and read requests from instruction fetch (inst port).
- Serves one request at a time from an internal word-addressed RAM, after a programmable latency.
- Reports per-port busy/done status on 2-bit buses that feed the stage's stall logic.

Parameters:
- DEPTH, 1024, RAM size in 32-bit words; power of two.
- LATENCY, 2, cycles from accept to done pulse; legal range 1..15.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- d_re  in  1  data-port read request; level, held until done_o[0].
- d_we  in  1  data-port write request; level, held until done_o[0].
- d_sel  in  4  byte-lane enables; bit i covers wdata[8i+7:8i].
- d_addr  in  32  data-port byte address.
- d_wdata  in  32  data-port write data.
- i_re  in  1  instruction-port read request; level.
- i_addr  in  32  instruction-port byte address.
- rdata_o  out  32  read data; valid in the done cycle, held until the next read completes.
- busy_o  out  2  bit0 = data port, bit1 = inst port; combinational.
- done_o  out  2  one-cycle completion pulse per port; registered.

Behaviour:
- Reset (rst=0, async): FSM goes to IDLE, done_o=0, rdata_o=0, counter=0, RR pointer=0. RAM contents are not cleared. busy_o is combinational and follows the requests.
- Word index = addr[log2(DEPTH)+1:2]. Upper bits and addr[1:0] are ignored, so addresses wrap modulo DEPTH*4.
- FSM states: IDLE, ACCESS.
- IDLE:
  - If any request is present, pick one owner (arbitration below).
  - Latch owner, word index, sel, wdata, and write flag (d_we; d_we wins if d_re=1 too).
  - Load counter=LATENCY-1 and go to ACCESS.
- ACCESS:
  - Decrement the counter each cycle.
  - At the edge where counter==0:
    - Write: commit only the lanes enabled by sel; d_sel=0 is a legal no-op write.
    - Read: load rdata_o with the full 32-bit word (sel ignored; the requester extracts bytes).
    - Pulse done_o[owner]=1 for exactly one cycle; return to IDLE.
- Timing: request seen in IDLE at cycle N, done_o high in cycle N+LATENCY. IDLE can accept a new request in cycle N+LATENCY+1, so back-to-back accesses are LATENCY+1 cycles apart.
- busy_o[k] = request_k & ~done_o[k]. Busy is high from the first request cycle through the cycle before done; a waiting (unserved) port stays busy.
- Arbitration (default): fixed priority, data port over inst port.
- Request withdrawn mid-ACCESS: the access still completes; the write is committed and done still pulses (the initiator may ignore it).
- Reset during ACCESS: aborts the access; no write commit, no done pulse.
- rdata_o is unchanged by writes and by reset-free idle cycles.

Optional Feature:
- MEM_RR_ARB_EN defined:
  - Round-robin arbitration. A 1-bit pointer names the preferred port; after each completion it points to the other port.
  - With both ports requesting continuously, service alternates data/inst.
- Undefined: fixed data-over-inst priority; the inst port can starve under continuous data traffic.

Test Plan:
- Reset: rst=0 with d_re=1 -> done_o=2'b00, rdata_o=0, busy_o=2'b01. Release rst: first done_o[0] appears 2 cycles after the first IDLE cycle.
- Word write then read: d_we=1, d_sel=4'hF, d_addr=0x10, d_wdata=0xDEADBEEF -> busy_o[0]=1 for 2 cycles, done_o=2'b01 at accept+2. Then d_re at 0x10 -> rdata_o=0xDEADBEEF in its done cycle.
- Byte-lane write: d_sel=4'b0100, d_wdata=0x00AA0000 to 0x10 -> read 0x10 returns 0xDEAABEEF.
- Contention: d_re@0x10 and i_re@0x20 asserted together ->
  - Default: done_o=2'b01 at N+2, 2'b10 at N+5; busy_o[1]=1 from N through N+4.
  - With MEM_RR_ARB_EN and both held: order alternates 01,10,01,10.
- Wrap: DEPTH=1024, read d_addr=0x1010 -> same data as 0x10 (0xDEAABEEF).
- Reset mid-access: write 0x12345678 to 0x40, assert rst=0 one cycle after accept -> no done pulse. A later read of 0x40 returns the prior content, not 0x12345678.
